fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end that produces `INST_F`/`PC_F`/`PC4_F` for the IF/ID pipeline register. It owns the program counter and drives a request/grant/response instruction-memory port with up to `DEPTH` requests in flight. Fetched instructions sit in a small queue so decode `stall` never loses data. A taken branch/jump `redirect` restarts fetch and discards every stale fetch in the queue and in flight.

## Interface
Parameters:
- `RESET_PC`, `32'h0000_0000`: PC fetched first after reset.
- `DEPTH`, `2`: maximum in-flight requests plus queued instructions; minimum 2.

Ports (clock `clk`; reset `rst`, synchronous, active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `stall`  in  1  decode cannot accept; hold current output
- `redirect`  in  1  branch/jump taken; flush and restart at `redirect_pc`
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (forced 0)
- `imem_req`  out  1  request valid
- `imem_addr`  out  32  word-aligned request address
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response data valid; responses return in request order
- `imem_rdata`  in  32  instruction word
- `inst_f`  out  32  instruction to IF/ID; `32'h0000_0013` (NOP) when `valid_f`=0
- `pc_f`  out  32  PC of `inst_f`; 0 when `valid_f`=0
- `pc4_f`  out  32  `pc_f`+4 (mod 2^32); 0 when `valid_f`=0
- `valid_f`  out  1  queue head holds a valid instruction

## Operation
- PC register: reset to `RESET_PC`. Increments by 4 on each accepted request (`imem_req && imem_gnt`). Wraps from `32'hFFFF_FFFC` to 0.
- `imem_addr` = PC register.
- Issue condition: `imem_req` = !`rst` && !`redirect` && (outstanding + queue_count − pop < `DEPTH`), where pop = `valid_f && !stall`.
- An accepted request pushes its PC into the address queue and increments `outstanding`.
- `imem_rvalid` decrements `outstanding` and pops the address queue.
  - If `kill_cnt` > 0: the response is dropped and `kill_cnt` decrements.
  - Otherwise: {rdata, pc} is pushed into the instruction queue.
- Output port shows the head of the instruction queue. It pops when `valid_f && !stall`.
- `stall` holds head and outputs unchanged. Fetching continues while credit remains.
- `redirect`, the cycle it is asserted:
  - PC ← {`redirect_pc`[31:2],2'b00}.
  - Instruction queue cleared.
  - `kill_cnt` ← outstanding − `imem_rvalid` (this cycle's response is dropped).
  - `imem_req` forced 0.
- Redirect has priority over `stall` and over any concurrent response.
- Redirect while `kill_cnt` > 0 adds the new outstanding count; `kill_cnt` never exceeds `outstanding`.
- Killed requests still consume credit until their responses return.
- Reset mid-operation: all counters, queues and PC return to reset values. The memory is reset by the same `rst`, so no stale responses arrive.
- A response with `outstanding`=0 is a protocol error; flag it with an assertion and drop the response.

## Timing
- Reset values: `imem_req`=0, `valid_f`=0, `inst_f`=NOP, `pc_f`=0, `pc4_f`=0, PC=`RESET_PC`, `outstanding`=`kill_cnt`=0.
- First request is asserted in the first cycle after `rst` deasserts.
- `imem_rvalid` in cycle N makes `valid_f`=1 in cycle N+1 (registered queue).
- Redirect in cycle N: `valid_f`=0 in N+1; request for `redirect_pc` issued in N+1.
- With a 0-wait grant and 1-cycle response, sustained throughput is 1 instruction/cycle at `DEPTH`=2.
- `imem_req` depends combinationally on `stall`, `redirect` and credit. No input-to-`inst_f` combinational path.

## Structure
- Shared package `riscv_pkg`: `NOP_INST` (`32'h0000_0013`) and an `inst_pc_t` struct {inst, pc}.
- One sub-module `fetch_fifo`: parameterised synchronous FIFO (width, depth) with push, pop, clear, count, empty and full.
  - Instantiated twice: address queue (32-bit) and instruction queue (`inst_pc_t`).

## Test plan
- Reset then free-run with 1-cycle memory returning `{pc}` as data:
  - `valid_f` rises in cycle 3 after reset release.
  - `pc_f` = 0,4,8,… every cycle; `pc4_f` = `pc_f`+4.
- `stall` held 3 cycles while `pc_f`=8:
  - Output holds 8 for all 3 cycles.
  - `imem_req` drops once credit is exhausted.
  - After release, 8,12,16 follow with no gap or duplicate.
- `redirect`=1 with `redirect_pc`=`32'h100` while 2 requests are in flight:
  - Both responses are dropped.
  - Next valid `pc_f` = `32'h100`, with no stale instruction ever visible.
- `redirect`=1 and `stall`=1 in the same cycle, `redirect_pc`=`32'h203`: queue flushed, fetch restarts at `32'h200`.
- Memory grants every other cycle with 2-cycle responses: order preserved, outstanding never exceeds 2.
- Start PC `32'hFFFF_FFF8`: sequence FFF8, FFFC, 0, 4.
- `rst` pulsed mid-stream with 2 in flight: next outputs start at `RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared front-end types and constants for the RISC-V core.
package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } inst_pc_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; used for the fetch address and instruction queues.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps up to DEPTH fetches in flight or queued,
// and flushes stale fetches on a branch/jump redirect.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f,
    output logic        valid_f
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] kill_q, kill_d;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] iq_count;
    logic [CNT_W:0]   used;
    logic [31:0]      aq_rdata;
    logic             aq_empty, aq_full;
    logic             iq_empty, iq_full;
    logic             accept, resp, iq_push, pop;
    inst_pc_t         iq_wdata;
    inst_pc_t         head;

    // Address queue depth equals the number of requests still awaiting a response.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .push  (accept),
        .wdata (pc_q),
        .pop   (resp),
        .rdata (aq_rdata),
        .count (outstanding),
        .empty (aq_empty),
        .full  (aq_full)
    );

    fetch_fifo #(
        .WIDTH ($bits(inst_pc_t)),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect),
        .push  (iq_push),
        .wdata (iq_wdata),
        .pop   (pop),
        .rdata (head),
        .count (iq_count),
        .empty (iq_empty),
        .full  (iq_full)
    );

    assign valid_f  = !iq_empty;
    assign pop      = valid_f && !stall;
    assign resp     = imem_rvalid && !aq_empty;
    assign iq_push  = resp && (kill_q == '0) && !redirect;
    assign iq_wdata = '{inst: imem_rdata, pc: aq_rdata};

    // Killed requests stay in the address queue, so they keep holding credit.
    assign used      = {1'b0, outstanding} + {1'b0, iq_count} - (CNT_W + 1)'(pop);
    assign imem_req  = !rst && !redirect && (used < (CNT_W + 1)'(DEPTH));
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_gnt;

    always_comb begin
        pc_d   = pc_q;
        kill_d = kill_q;
        if (redirect) begin
            pc_d   = {redirect_pc[31:2], 2'b00};
            kill_d = outstanding - CNT_W'(resp);
        end else begin
            if (accept) pc_d = pc_q + 32'd4;
            if (resp && (kill_q != '0)) kill_d = kill_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            kill_q <= '0;
        end else begin
            pc_q   <= pc_d;
            kill_q <= kill_d;
        end
    end

    always_comb begin
        inst_f = NOP_INST;
        pc_f   = '0;
        pc4_f  = '0;
        if (valid_f) begin
            inst_f = head.inst;
            pc_f   = head.pc;
            pc4_f  = head.pc + 32'd4;
        end
    end

    // A response with nothing outstanding is a memory protocol error; it is dropped.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (outstanding != '0));
    a_aq_no_overflow: assert property (@(posedge clk) disable iff (rst)
        accept |-> !aq_full);
    a_iq_no_overflow: assert property (@(posedge clk) disable iff (rst)
        iq_push |-> !iq_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus scoreboarded multi-cycle sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst_f;
    logic [31:0] pc_f;
    logic [31:0] pc4_f;
    logic        valid_f;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_f      (inst_f),
        .pc_f        (pc_f),
        .pc4_f       (pc4_f),
        .valid_f     (valid_f)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t       pend[$];
    vec_t        vecs[19];
    int          cyc = 0;
    int          lat = 1;
    bit          gnt_alt = 1'b0;
    bit          sb_on = 1'b0;
    logic [31:0] exp_pc = '0;
    int          n_valid = 0;
    int          max_out = 0;
    logic        last_req;
    logic [31:0] last_addr;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock cycle: memory model drives responses, scoreboard checks mid-cycle.
    task automatic cycle();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr;
        end
        imem_gnt = gnt_alt ? cyc[0] : 1'b1;
        #3;
        last_req  = imem_req;
        last_addr = imem_addr;
        if (sb_on && valid_f) begin
            check("sb_pc", pc_f, exp_pc);
            check("sb_inst", inst_f, exp_pc);
            check("sb_pc4", pc4_f, exp_pc + 32'd4);
            n_valid++;
            if (!stall && !redirect) exp_pc = exp_pc + 32'd4;
        end
        if (imem_rvalid) void'(pend.pop_front());
        if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
        if (pend.size() > max_out) max_out = pend.size();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) pend.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        //         rst   stall redir rpc           req   valid pc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h4};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h8};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h8};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h8};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,      1'b0, 1'b1, 32'h8};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'hC};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h10};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h14};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h100,    1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h100};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h104};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h203,    1'b0, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h200};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b1, 32'h204};

        @(posedge clk);
        #1;

        // Table: 1-cycle memory, grant always.
        for (int i = 0; i < 19; i++) begin
            rst         = vecs[i].rst;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            cycle();
            check($sformatf("v%0d_req", i), 32'(last_req), 32'(vecs[i].exp_req));
            check($sformatf("v%0d_valid", i), 32'(valid_f), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_pc", i), pc_f, vecs[i].exp_valid ? vecs[i].exp_pc : 32'h0);
            check($sformatf("v%0d_pc4", i), pc4_f,
                  vecs[i].exp_valid ? vecs[i].exp_pc + 32'd4 : 32'h0);
            check($sformatf("v%0d_inst", i), inst_f,
                  vecs[i].exp_valid ? vecs[i].exp_pc : 32'h0000_0013);
        end
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Redirect with two requests in flight (2-cycle memory).
        lat = 2;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb_on = 1'b1; exp_pc = 32'h0; n_valid = 0;
        for (int i = 0; i < 20 && pend.size() != 2; i++) cycle();
        check("inflight2_redir", 32'(pend.size()), 32'd2);
        redirect = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect = 1'b0;
        exp_pc = 32'h100; n_valid = 0;
        check("redir_valid_n1", 32'(valid_f), 32'd0);
        cycle();
        check("redir_req_n1", 32'(last_req), 32'd1);
        check("redir_addr_n1", last_addr, 32'h100);
        repeat (12) cycle();
        check("redir_progress", 32'(n_valid >= 3), 32'd1);

        // Alternate-cycle grants, 2-cycle responses, restart near the top of memory.
        gnt_alt = 1'b1; max_out = 0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        exp_pc = 32'hFFFF_FFF8; n_valid = 0;
        repeat (24) cycle();
        check("wrap_progress", 32'(n_valid >= 4), 32'd1);
        check("max_outstanding", 32'(max_out <= 2), 32'd1);

        // Reset pulse with two requests in flight.
        gnt_alt = 1'b0;
        for (int i = 0; i < 20 && pend.size() != 2; i++) cycle();
        check("inflight2_rst", 32'(pend.size()), 32'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_pc = 32'h0; n_valid = 0;
        check("rst_valid", 32'(valid_f), 32'd0);
        check("rst_inst", inst_f, 32'h0000_0013);
        check("rst_pc", pc_f, 32'h0);
        check("rst_pc4", pc4_f, 32'h0);
        cycle();
        check("rst_req", 32'(last_req), 32'd1);
        check("rst_addr", last_addr, 32'h0);
        repeat (11) cycle();
        check("rst_progress", 32'(n_valid >= 3), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
